// File: rtl/wb_intern_xbar.sv
// wb_intern_xbar: one Wishbone master (PCI target FSM) to NUM_SLAVES slaves.
// The slave-select field in the master address picks the slave. Addresses
// that decode past the last slave are answered locally with an error. Error
// status is sticky and is cleared with ERR_CLR_I.
// Optional build macro: WB_XBAR_TIMEOUT_EN adds a BUSY-state ACK watchdog
// that ends a stalled access with an error after TIMEOUT_CYC cycles.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no access in flight, waiting for master STB
// ST_BUSY    | request registered onto the selected slave, waiting for ACK
// ST_RELEASE | master ACK issued, waiting for master STB to drop
module wb_intern_xbar #(
    parameter int                NUM_SLAVES  = 5,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                SEL_LSB     = 12,
    parameter int                SEL_W       = 3,
    parameter int                TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                         PHY_CLK33_I,
    input  logic                         PHY_RST_I,
    input  logic [ADDR_W-1:0]            M_WB_ADD_I,
    input  logic [DATA_W-1:0]            M_WB_DATA_I,
    output logic [DATA_W-1:0]            M_WB_DATA_O,
    input  logic                         M_WB_STB_I,
    input  logic                         M_WB_WE_I,
    output logic                         M_WB_ACK_O,
    output logic                         M_WB_VALID_O,
    output logic [NUM_SLAVES*ADDR_W-1:0] S_WB_ADD_O,
    output logic [NUM_SLAVES*DATA_W-1:0] S_WB_DATA_O,
    input  logic [NUM_SLAVES*DATA_W-1:0] S_WB_DATA_I,
    output logic [NUM_SLAVES-1:0]        S_WB_STB_O,
    output logic [NUM_SLAVES-1:0]        S_WB_WE_O,
    input  logic [NUM_SLAVES-1:0]        S_WB_ACK_I,
    input  logic [NUM_SLAVES-1:0]        S_WB_VALID_I,
    input  logic                         ERR_CLR_I,
    output logic                         ERR_FLAG_O,
    output logic                         ERR_TO_O,
    output logic [ADDR_W-1:0]            ERR_ADD_O
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Reject parameter sets the decoder cannot represent.
    if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || (1 << SEL_W) < NUM_SLAVES ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_params
        $error("wb_intern_xbar: illegal parameter combination");
    end

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   add_q, add_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                stb_q, stb_d;
    logic                ack_q, ack_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_flag_q, err_flag_d;
    logic [ADDR_W-1:0]   err_add_q, err_add_d;
`ifdef WB_XBAR_TIMEOUT_EN
    logic                err_to_q, err_to_d;
    logic [15:0]         cnt_q, cnt_d;
`endif

    logic [SEL_W-1:0]    m_idx;
    logic                m_idx_ok;
    logic                sel_ack;
    logic                sel_valid;
    logic [DATA_W-1:0]   sel_rdata;

    assign m_idx    = M_WB_ADD_I[SEL_LSB +: SEL_W];
    assign m_idx_ok = (int'(m_idx) < NUM_SLAVES);

    // Pick the response of the latched slave; all other slaves are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_valid = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ack   = S_WB_ACK_I[i];
                sel_valid = S_WB_VALID_I[i];
                sel_rdata = S_WB_DATA_I[i*DATA_W +: DATA_W];
            end
        end
    end

    // Fan the registered request out to the selected slave only; others see 0.
    always_comb begin
        S_WB_STB_O  = '0;
        S_WB_WE_O   = '0;
        S_WB_ADD_O  = '0;
        S_WB_DATA_O = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (stb_q && (idx_q == SEL_W'(i))) begin
                S_WB_STB_O[i]                  = 1'b1;
                S_WB_WE_O[i]                   = we_q;
                S_WB_ADD_O[i*ADDR_W +: ADDR_W] = add_q;
                S_WB_DATA_O[i*DATA_W +: DATA_W] = wdata_q;
            end
        end
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        add_d      = add_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        stb_d      = stb_q;
        ack_d      = 1'b0;
        valid_d    = 1'b0;
        rdata_d    = rdata_q;
        // Clear first so that an error raised in the same cycle overrides it.
        err_flag_d = ERR_CLR_I ? 1'b0 : err_flag_q;
        err_add_d  = ERR_CLR_I ? '0   : err_add_q;
`ifdef WB_XBAR_TIMEOUT_EN
        err_to_d   = ERR_CLR_I ? 1'b0 : err_to_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (M_WB_STB_I) begin
                    if (m_idx_ok) begin
                        idx_d   = m_idx;
                        add_d   = M_WB_ADD_I;
                        wdata_d = M_WB_DATA_I;
                        we_d    = M_WB_WE_I;
                        stb_d   = 1'b1;
                        state_d = ST_BUSY;
`ifdef WB_XBAR_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        ack_d      = 1'b1;
                        valid_d    = 1'b0;
                        rdata_d    = ERR_DATA;
                        err_flag_d = 1'b1;
                        err_add_d  = M_WB_ADD_I;
`ifdef WB_XBAR_TIMEOUT_EN
                        err_to_d   = 1'b0;
`endif
                        state_d    = ST_RELEASE;
                    end
                end
            end
            ST_BUSY: begin
                if (!M_WB_STB_I) begin
                    // Master abandoned the access: drop the slave, no ACK.
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    valid_d = sel_valid;
                    rdata_d = sel_rdata;
                    state_d = ST_RELEASE;
                end
`ifdef WB_XBAR_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYC)) begin
                    stb_d      = 1'b0;
                    ack_d      = 1'b1;
                    valid_d    = 1'b0;
                    rdata_d    = ERR_DATA;
                    err_flag_d = 1'b1;
                    err_to_d   = 1'b1;
                    err_add_d  = add_q;
                    state_d    = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_RELEASE: begin
                if (!M_WB_STB_I) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any slave strobe at once.
    always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
        if (PHY_RST_I) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            add_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            stb_q      <= 1'b0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            err_flag_q <= 1'b0;
            err_add_q  <= '0;
`ifdef WB_XBAR_TIMEOUT_EN
            err_to_q   <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            add_q      <= add_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            stb_q      <= stb_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            err_add_q  <= err_add_d;
`ifdef WB_XBAR_TIMEOUT_EN
            err_to_q   <= err_to_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign M_WB_ACK_O   = ack_q;
    assign M_WB_VALID_O = valid_q;
    assign M_WB_DATA_O  = rdata_q;
    assign ERR_FLAG_O   = err_flag_q;
    assign ERR_ADD_O    = err_add_q;
`ifdef WB_XBAR_TIMEOUT_EN
    assign ERR_TO_O     = err_to_q;
`else
    assign ERR_TO_O     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_intern_xbar.sv
// Directed bench for wb_intern_xbar (NUM_SLAVES = 5, 32-bit bus).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Timeout steps are included only when WB_XBAR_TIMEOUT_EN is defined.
module tb_wb_intern_xbar;

    localparam int NS = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   m_add;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_stb;
    logic            m_we;
    logic            m_ack;
    logic            m_valid;
    logic [NS*AW-1:0] s_add;
    logic [NS*DW-1:0] s_wdata;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]   s_stb;
    logic [NS-1:0]   s_we;
    logic [NS-1:0]   s_ack;
    logic [NS-1:0]   s_valid;
    logic            err_clr;
    logic            err_flag;
    logic            err_to;
    logic [AW-1:0]   err_add;

    int errors = 0;
    int checks = 0;

    wb_intern_xbar #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SEL_LSB    (12),
        .SEL_W      (3),
        .TIMEOUT_CYC(8),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .PHY_CLK33_I (clk),
        .PHY_RST_I   (rst),
        .M_WB_ADD_I  (m_add),
        .M_WB_DATA_I (m_wdata),
        .M_WB_DATA_O (m_rdata),
        .M_WB_STB_I  (m_stb),
        .M_WB_WE_I   (m_we),
        .M_WB_ACK_O  (m_ack),
        .M_WB_VALID_O(m_valid),
        .S_WB_ADD_O  (s_add),
        .S_WB_DATA_O (s_wdata),
        .S_WB_DATA_I (s_rdata),
        .S_WB_STB_O  (s_stb),
        .S_WB_WE_O   (s_we),
        .S_WB_ACK_I  (s_ack),
        .S_WB_VALID_I(s_valid),
        .ERR_CLR_I   (err_clr),
        .ERR_FLAG_O  (err_flag),
        .ERR_TO_O    (err_to),
        .ERR_ADD_O   (err_add)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic slaves_quiet();
        s_ack   = '0;
        s_valid = '0;
    endtask

    initial begin
        rst = 1'b1; m_add = '0; m_wdata = '0; m_stb = 1'b0; m_we = 1'b0;
        s_rdata = '0; s_ack = '0; s_valid = '0; err_clr = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_ack",     64'(m_ack),    64'd0);
        chk("rst_valid",   64'(m_valid),  64'd0);
        chk("rst_rdata",   64'(m_rdata),  64'd0);
        chk("rst_s_stb",   64'(s_stb),    64'd0);
        chk("rst_s_we",    64'(s_we),     64'd0);
        chk("rst_s_add_lo", s_add[63:0],  64'd0);
        chk("rst_err_flag",64'(err_flag), 64'd0);
        chk("rst_err_to",  64'(err_to),   64'd0);
        chk("rst_err_add", 64'(err_add),  64'd0);
        rst = 1'b0;
        tick();

        // Read slave 1; foreign ACKs during BUSY must be ignored
        m_add = 32'h0000_1004; m_we = 1'b0; m_stb = 1'b1;
        tick();
        chk("rd1_s_stb",   64'(s_stb),         64'b00010);
        chk("rd1_s_we",    64'(s_we),          64'b00000);
        chk("rd1_s_add1",  64'(s_add[32 +: 32]), 64'h0000_1004);
        chk("rd1_s_add0",  64'(s_add[0 +: 32]),  64'd0);
        chk("rd1_ack_early", 64'(m_ack),       64'd0);
        s_ack = 5'b00101; s_valid = 5'b00101;
        tick();
        chk("rd1_foreign_ack", 64'(m_ack),     64'd0);
        chk("rd1_s_stb_hold",  64'(s_stb),     64'b00010);
        slaves_quiet();
        tick();
        chk("rd1_s_stb_wait",  64'(s_stb),     64'b00010);
        s_rdata[32 +: 32] = 32'h1234_5678; s_ack[1] = 1'b1; s_valid[1] = 1'b1;
        tick();
        chk("rd1_ack",     64'(m_ack),   64'd1);
        chk("rd1_valid",   64'(m_valid), 64'd1);
        chk("rd1_data",    64'(m_rdata), 64'h1234_5678);
        chk("rd1_s_stb_off", 64'(s_stb), 64'd0);
        slaves_quiet(); m_stb = 1'b0;
        tick();
        chk("rd1_ack_pulse", 64'(m_ack), 64'd0);
        chk("rd1_data_hold", 64'(m_rdata), 64'h1234_5678);

        // Write slave 4 (highest valid index)
        m_add = 32'h0000_4000; m_wdata = 32'hA5A5_0001; m_we = 1'b1; m_stb = 1'b1;
        tick();
        chk("wr4_s_stb",   64'(s_stb),               64'b10000);
        chk("wr4_s_we",    64'(s_we),                64'b10000);
        chk("wr4_s_data4", 64'(s_wdata[128 +: 32]),  64'hA5A5_0001);
        chk("wr4_s_data_lo", s_wdata[63:0],          64'd0);
        chk("wr4_s_add4",  64'(s_add[128 +: 32]),    64'h0000_4000);
        s_rdata[128 +: 32] = 32'hCAFE_0004; s_ack[4] = 1'b1; s_valid[4] = 1'b1;
        tick();
        chk("wr4_ack",     64'(m_ack),   64'd1);
        chk("wr4_valid",   64'(m_valid), 64'd1);
        chk("wr4_data",    64'(m_rdata), 64'hCAFE_0004);
        slaves_quiet(); m_stb = 1'b0; m_we = 1'b0;
        tick();

        // Decode error: index 7
        m_add = 32'h0000_7000; m_stb = 1'b1;
        tick();
        chk("dec_ack",     64'(m_ack),    64'd1);
        chk("dec_valid",   64'(m_valid),  64'd0);
        chk("dec_data",    64'(m_rdata),  64'hDEAD_BEEF);
        chk("dec_flag",    64'(err_flag), 64'd1);
        chk("dec_to",      64'(err_to),   64'd0);
        chk("dec_add",     64'(err_add),  64'h0000_7000);
        chk("dec_s_stb",   64'(s_stb),    64'd0);
        tick();
        chk("dec_release_ack", 64'(m_ack), 64'd0);
        m_stb = 1'b0;
        tick();
        chk("dec_sticky",  64'(err_flag), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_flag",    64'(err_flag), 64'd0);
        chk("clr_to",      64'(err_to),   64'd0);
        chk("clr_add",     64'(err_add),  64'd0);
        chk("clr_data_hold", 64'(m_rdata), 64'hDEAD_BEEF);

        // Index 5 (== NUM_SLAVES) errors; new error beats a simultaneous clear
        m_add = 32'h0000_5000; m_stb = 1'b1; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("setwin_ack",  64'(m_ack),    64'd1);
        chk("setwin_flag", 64'(err_flag), 64'd1);
        chk("setwin_add",  64'(err_add),  64'h0000_5000);
        m_stb = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Abort: master drops STB mid-BUSY, late slave ACK ignored
        m_add = 32'h0000_0010; m_stb = 1'b1;
        tick();
        chk("abt_s_stb",   64'(s_stb), 64'b00001);
        m_stb = 1'b0;
        tick();
        chk("abt_s_stb_off", 64'(s_stb), 64'd0);
        chk("abt_no_ack",  64'(m_ack), 64'd0);
        s_ack[0] = 1'b1; s_valid[0] = 1'b1;
        tick();
        chk("abt_late_ack", 64'(m_ack), 64'd0);
        chk("abt_s_stb_idle", 64'(s_stb), 64'd0);
        slaves_quiet();
        tick();

`ifdef WB_XBAR_TIMEOUT_EN
        // Timeout: slave 2 never answers
        m_add = 32'h0000_2000; m_stb = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_wait_ack", 64'(m_ack), 64'd0);
            chk("to_wait_stb", 64'(s_stb), 64'b00100);
        end
        tick();
        chk("to_ack",      64'(m_ack),    64'd1);
        chk("to_valid",    64'(m_valid),  64'd0);
        chk("to_data",     64'(m_rdata),  64'hDEAD_BEEF);
        chk("to_flag",     64'(err_flag), 64'd1);
        chk("to_to",       64'(err_to),   64'd1);
        chk("to_add",      64'(err_add),  64'h0000_2000);
        chk("to_s_stb",    64'(s_stb),    64'd0);
        m_stb = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Slave ACK on the expiry cycle wins
        m_add = 32'h0000_2000; m_stb = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        s_rdata[64 +: 32] = 32'h0BAD_F00D; s_ack[2] = 1'b1; s_valid[2] = 1'b1;
        tick();
        chk("toack_ack",   64'(m_ack),    64'd1);
        chk("toack_valid", 64'(m_valid),  64'd1);
        chk("toack_data",  64'(m_rdata),  64'h0BAD_F00D);
        chk("toack_flag",  64'(err_flag), 64'd0);
        chk("toack_to",    64'(err_to),   64'd0);
        slaves_quiet(); m_stb = 1'b0;
        tick();
`endif

        // Leave an error pending, then reset during BUSY
        m_add = 32'h0000_6000; m_stb = 1'b1;
        tick();
        m_stb = 1'b0;
        tick();
        chk("pre_rst_flag", 64'(err_flag), 64'd1);
        m_add = 32'h0000_2008; m_stb = 1'b1;
        tick();
        chk("rstb_s_stb",  64'(s_stb), 64'b00100);
        rst = 1'b1;
        #1;
        chk("rstb_async_stb", 64'(s_stb),    64'd0);
        chk("rstb_s_add2",  64'(s_add[64 +: 32]), 64'd0);
        chk("rstb_ack",     64'(m_ack),    64'd0);
        chk("rstb_flag",    64'(err_flag), 64'd0);
        chk("rstb_err_add", 64'(err_add),  64'd0);
        chk("rstb_rdata",   64'(m_rdata),  64'd0);
        m_stb = 1'b0;
        tick();
        chk("rstb_no_ack",  64'(m_ack), 64'd0);
        rst = 1'b0;
        tick();

        // Normal transaction after reset; slave reports VALID = 0
        m_add = 32'h0000_3010; m_stb = 1'b1;
        tick();
        chk("post_s_stb",  64'(s_stb), 64'b01000);
        s_rdata[96 +: 32] = 32'h0000_55AA; s_ack[3] = 1'b1; s_valid[3] = 1'b0;
        tick();
        chk("post_ack",    64'(m_ack),    64'd1);
        chk("post_valid",  64'(m_valid),  64'd0);
        chk("post_data",   64'(m_rdata),  64'h0000_55AA);
        chk("post_flag",   64'(err_flag), 64'd0);
        slaves_quiet(); m_stb = 1'b0;
        tick();
        chk("post_idle_stb", 64'(s_stb), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
